simd_mac_acc: RTL
=================

Name: simd_mac_acc

Overview:
- Parametrised, pipelined packed-SIMD multiply-accumulate engine; next generation of the combinational four-lane MAC in the ML accelerator.
- Each accepted beat multiplies LANES packed operand pairs, masks inactive lanes, reduces them to one beat sum, and accumulates across a multi-beat packet.
- Returns one result per packet (terminated by in_last) over a valid/ready handshake, with signed/unsigned mode, optional saturation and an overflow flag.

Parameters:
- LANES, 4, number of multiplier lanes packed into each operand word.
- LANE_W, 8, bits per lane operand.
- ACC_W, 32, accumulator/result width; must be >= 2*LANE_W + clog2(LANES).
- SAT, 0, 1 = clamp on overflow, 0 = two's-complement wrap.
- BEAT_W, 16, width of the per-packet beat counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  LANES*LANE_W  operand A; lane i = bits [i*LANE_W +: LANE_W].
- in_b  in  LANES*LANE_W  operand B, same packing.
- in_lanes  in  clog2(LANES+1)  active lane count; lanes 0..in_lanes-1 are used; 0 means all LANES.
- in_last  in  1  beat closes the packet.
- in_signed  in  1  1 = signed lanes, 0 = unsigned; sampled on the first beat of the packet only.
- out_valid  out  1  packet result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  packet accumulation result.
- out_ovf  out  1  overflow occurred at any point in the packet (sticky per packet).
- out_beats  out  BEAT_W  beats in the packet; saturates at all-ones.

Behaviour:
- Reset (async, any time):
  - Clear stage valids, accumulator, mode latch, overflow sticky and beat counter.
  - out_valid=0, out_data=0, out_ovf=0, out_beats=0.
  - A partial packet is discarded; the first beat accepted after reset starts a new packet.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every pipeline register holds its value.
  - The result transfers when out_valid && out_ready.
- Pipeline, accept at cycle N:
  - S1 (registered at N+1): per-lane product, 2*LANE_W bits, sign- or zero-extended per the packet mode. Lanes >= effective lane count contribute 0. Register the lane sum as the beat sum (2*LANE_W + clog2(LANES) bits) together with its last flag.
  - S2 (registered at N+2), non-last beat: acc <= acc + beat_sum; beats++.
  - S2 (registered at N+2), last beat: out_data <= acc + beat_sum (sat/wrap applied); out_ovf <= sticky | this-beat overflow; out_beats <= beats+1. Then acc, sticky and beats clear to 0 and out_valid <= 1.
  - Latency: last beat accepted at N gives out_valid high at N+2.
  - Throughput: 1 beat/cycle when not stalled.
- out_valid stays high with out_data, out_ovf and out_beats stable until accepted.
  - It drops the cycle after acceptance, unless another last beat completes in that same cycle, in which case new data loads and out_valid stays 1.
- Mode:
  - A first-of-packet beat latches in_signed. Later beats ignore in_signed.
  - A single-beat packet uses its own in_signed.
- Overflow:
  - Signed mode: detected when the sign of acc + beat_sum disagrees with the sign of both operands (signed add overflow).
  - Unsigned mode: detected on carry out of ACC_W.
  - SAT=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) (signed), or 2^ACC_W-1 (unsigned). Further accumulation continues from the clamped value.
  - SAT=0: wrap.
  - In both cases the sticky flag is set.
- in_lanes > LANES is treated as LANES.
- Beat counter saturates at 2^BEAT_W-1. The accumulation itself is unaffected by counter saturation.

Test Plan:
All cases use defaults unless noted.
- Single beat, last=1, signed, in_lanes=0: a=0x04030201, b=0x01010101 accepted at cycle N -> out_valid at N+2, out_data=10, out_beats=1, out_ovf=0.
- Lane masking: in_lanes=2, a=0x7F7F0302, b=0x7F7F0504, last=1 -> out_data=23 (2*4+3*5).
- Mode: in_lanes=1, a=0x000000FF, b=0x00000005: signed -> out_data=0xFFFFFFFB (-5); unsigned -> out_data=1275. A 2-beat packet with in_signed=1 on beat 0 and 0 on beat 1 -> signed result.
- Backpressure: out_ready=0 for 3 cycles after out_valid while in_valid=1 streams -> in_ready=0, out_data stable, no beats lost. The next packet's result equals its standalone value.
- Overflow with ACC_W=18, all lanes 0x7F*0x7F, 3 beats, signed:
  - SAT=1 -> out_data=0x1FFFF, out_ovf=1, out_beats=3.
  - SAT=0 -> out_data=0x2F40C, out_ovf=1.
- Reset mid-packet: 2 non-last beats of sum 100, pulse rst asynchronously between edges, then a 1-beat packet with sum 7 -> out_data=7, out_beats=1. Outputs read 0 during rst.

Source files
------------

// File: rtl/simd_mac_acc.sv
// rtl/simd_mac_acc.sv - packed-SIMD multiply-accumulate engine with per-packet results
// Two-stage pipeline: lane products and beat sum, then packet accumulation.
module simd_mac_acc #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int ACC_W  = 32,
    parameter int SAT    = 0,
    parameter int BEAT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*LANE_W-1:0]       in_a,
    input  logic [LANES*LANE_W-1:0]       in_b,
    input  logic [$clog2(LANES+1)-1:0]    in_lanes,
    input  logic                          in_last,
    input  logic                          in_signed,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data,
    output logic                          out_ovf,
    output logic [BEAT_W-1:0]             out_beats
);

    localparam int PW  = 2 * LANE_W;
    localparam int BSW = PW + $clog2(LANES);

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic              stall;
    logic              accept;
    logic              first_q;
    logic              mode_q;
    logic              eff_signed;
    int                n_act;

    logic [PW-1:0]     a_ext, b_ext, prod;
    logic [BSW-1:0]    prod_ext;
    logic [BSW-1:0]    beat_sum_d;

    logic              s1_valid_q;
    logic              s1_last_q;
    logic              s1_signed_q;
    logic [BSW-1:0]    s1_sum_q;

    logic [ACC_W-1:0]  acc_q;
    logic              sticky_q;
    logic [BEAT_W-1:0] beats_q;
    logic [ACC_W:0]    acc_x, bs_x, sum_x;
    logic              ovf;
    logic [ACC_W-1:0]  acc_d;
    logic [BEAT_W-1:0] beats_d;

    logic              out_valid_q;
    logic [ACC_W-1:0]  out_data_q;
    logic              out_ovf_q;
    logic [BEAT_W-1:0] out_beats_q;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_beats = out_beats_q;

    // The first beat of a packet supplies its own mode; later beats reuse the latch.
    assign eff_signed = first_q ? in_signed : mode_q;

    always_comb begin
        beat_sum_d = '0;
        a_ext      = '0;
        b_ext      = '0;
        prod       = '0;
        prod_ext   = '0;
        n_act      = (in_lanes == '0 || int'(in_lanes) > LANES) ? LANES : int'(in_lanes);
        for (int i = 0; i < LANES; i++) begin
            if (eff_signed) begin
                a_ext = PW'($signed(in_a[i*LANE_W +: LANE_W]));
                b_ext = PW'($signed(in_b[i*LANE_W +: LANE_W]));
            end else begin
                a_ext = PW'(in_a[i*LANE_W +: LANE_W]);
                b_ext = PW'(in_b[i*LANE_W +: LANE_W]);
            end
            prod     = a_ext * b_ext;
            prod_ext = eff_signed ? BSW'($signed(prod)) : BSW'(prod);
            if (i < n_act) begin
                beat_sum_d = beat_sum_d + prod_ext;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q     <= 1'b1;
            mode_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_sum_q    <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                first_q     <= in_last;
                s1_sum_q    <= beat_sum_d;
                s1_last_q   <= in_last;
                s1_signed_q <= eff_signed;
                if (first_q) begin
                    mode_q <= in_signed;
                end
            end
        end
    end

    // One extra bit holds the unsigned carry; signed overflow comes from the sign bits.
    always_comb begin
        acc_x = s1_signed_q ? (ACC_W+1)'($signed(acc_q))    : (ACC_W+1)'(acc_q);
        bs_x  = s1_signed_q ? (ACC_W+1)'($signed(s1_sum_q)) : (ACC_W+1)'(s1_sum_q);
        sum_x = acc_x + bs_x;
        if (s1_signed_q) begin
            ovf = (acc_q[ACC_W-1] == bs_x[ACC_W-1]) && (sum_x[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            ovf = sum_x[ACC_W];
        end
        acc_d = sum_x[ACC_W-1:0];
        if (SAT != 0 && ovf) begin
            if (s1_signed_q) begin
                acc_d = acc_q[ACC_W-1] ? SMIN : SMAX;
            end else begin
                acc_d = '1;
            end
        end
        beats_d = (&beats_q) ? beats_q : beats_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (!stall && s1_valid_q) begin
                if (s1_last_q) begin
                    out_data_q  <= acc_d;
                    out_ovf_q   <= sticky_q | ovf;
                    out_beats_q <= beats_d;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    sticky_q    <= 1'b0;
                    beats_q     <= '0;
                end else begin
                    acc_q    <= acc_d;
                    sticky_q <= sticky_q | ovf;
                    beats_q  <= beats_d;
                end
            end
        end
    end

endmodule
